// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared constants and helpers for the debounced PIO input port
//
// Holds the register address map, the EDGE_MODE encodings and the helper
// that decides whether a debounced transition should set a capture bit.

package pio_pkg;

    // Register map (Avalon word addresses)
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // EDGE_MODE encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Selects which debounced transition sets an edgecapture bit.
    function automatic logic edge_match(input int mode, input logic rise, input logic fall);
        case (mode)
            EDGE_RISE: return rise;
            EDGE_FALL: return fall;
            EDGE_ANY:  return rise | fall;
            default:   return rise;
        endcase
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// rtl/pio_debounce_bit.sv - synchroniser, debounce counter and stable flop for one input bit
//
// Ports:
//   clk      system clock
//   reset    asynchronous reset, active-high
//   pin_i    asynchronous pin input
//   stable_o debounced stable value
//   rise_o   high in the cycle before stable_o goes 0->1 (aligned with the update edge)
//   fall_o   high in the cycle before stable_o goes 1->0 (aligned with the update edge)

module pio_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    // With debounce bypassed the stable flop itself acts as the last
    // synchroniser stage, so pin-to-stable latency stays SYNC_STAGES edges.
    localparam int CHAIN = (DEBOUNCE_CYCLES == 0) ? SYNC_STAGES - 1 : SYNC_STAGES;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

    logic [CHAIN-1:0] sync_q;
    logic [CHAIN-1:0] sync_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             sync_w;

    // Shift the pin in at bit 0; the oldest sample sits at the top.
    assign sync_d = CHAIN'({sync_q, pin_i});
    assign sync_w = sync_q[CHAIN-1];

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (DEBOUNCE_CYCLES == 0) begin
            stable_d = sync_w;
        end else if (sync_w != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_w;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Any return to the stable level leaves cnt_d at 0, restarting the count.
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = stable_d & ~stable_q;
    assign fall_o   = ~stable_d & stable_q;

endmodule

// File: rtl/pio_in_debounced.sv
// rtl/pio_in_debounced.sv - Avalon-MM debounced input port with edge capture and masked IRQ
//
// Ports:
//   clk         system clock
//   reset       asynchronous reset, active-high
//   address     register select (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect  slave select
//   write       write strobe, qualified by chipselect
//   writedata   write data; only the low WIDTH bits are used
//   in_port     asynchronous pin inputs
//   readdata    registered read data, one cycle latency
//   irq         level interrupt, |(edgecapture & irqmask)

module pio_in_debounced
    import pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] edge_set_w;

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .pin_i    (in_port[i]),
            .stable_o (stable_w[i]),
            .rise_o   (rise_w[i]),
            .fall_o   (fall_w[i])
        );
        assign edge_set_w[i] = edge_match(EDGE_MODE, rise_w[i], fall_w[i]);
    end

    if (WIDTH < 32) begin : g_unused
        logic unused_writedata;
        assign unused_writedata = ^writedata[31:WIDTH];
    end

    always_comb begin
        wr_en    = chipselect & write;
        mask_d   = mask_q;
        edge_clr = '0;
        rdata_d  = '0;

        if (wr_en && address == PIO_ADDR_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == PIO_ADDR_EDGE) begin
            edge_clr = writedata[WIDTH-1:0];
        end
        // Set is applied after clear so a same-edge capture is never lost.
        edge_d = (edge_q & ~edge_clr) | edge_set_w;

        // Muxes registered state, so a same-edge write is not yet visible.
        case (address)
            PIO_ADDR_DATA: rdata_d[WIDTH-1:0] = stable_w;
            PIO_ADDR_RSVD: rdata_d = '0;
            PIO_ADDR_MASK: rdata_d[WIDTH-1:0] = mask_q;
            PIO_ADDR_EDGE: rdata_d[WIDTH-1:0] = edge_q;
            default:       rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q  <= '0;
            edge_q  <= '0;
            rdata_q <= '0;
        end else begin
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_in_debounced.sv
// tb/tb_pio_in_debounced.sv - self-checking bench for pio_in_debounced

module tb_pio_in_debounced;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address_a, address_b;
    logic        chipselect_a, chipselect_b;
    logic        write_a, write_b;
    logic [31:0] writedata_a, writedata_b;
    logic [7:0]  in_port_a, in_port_b;
    logic [31:0] readdata_a, readdata_b;
    logic        irq_a, irq_b;

    always #5 clk = ~clk;

    pio_in_debounced #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .address(address_a), .chipselect(chipselect_a),
        .write(write_a), .writedata(writedata_a), .in_port(in_port_a),
        .readdata(readdata_a), .irq(irq_a)
    );

    pio_in_debounced #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .address(address_b), .chipselect(chipselect_b),
        .write(write_b), .writedata(writedata_b), .in_port(in_port_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          sel;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        bit          do_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
        string       name;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_irq(input bit sel, input logic exp, input string name);
        check(name, {31'b0, (sel ? irq_b : irq_a)}, {31'b0, exp});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_bus(input bit sel, input logic [1:0] addr, input logic cs,
                           input logic wr, input logic [31:0] data);
        if (sel) begin
            address_b = addr; chipselect_b = cs; write_b = wr; writedata_b = data;
        end else begin
            address_a = addr; chipselect_a = cs; write_a = wr; writedata_a = data;
        end
    endtask

    // Expected read value is queued when the address is on the bus and
    // compared once the registered readdata appears after the next edge.
    task automatic expect_rd(input bit sel, input logic [31:0] exp, input string name);
        sb_t e;
        e.name = name; e.sel = sel; e.exp = exp;
        sbq.push_back(e);
        cyc(1);
        e = sbq.pop_front();
        check(e.name, e.sel ? readdata_b : readdata_a, e.exp);
    endtask

    task automatic wr(input bit sel, input logic [1:0] addr, input logic [31:0] data);
        set_bus(sel, addr, 1'b1, 1'b1, data);
        cyc(1);
        set_bus(sel, addr, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd(input bit sel, input logic [1:0] addr, input logic [31:0] exp,
                      input string name);
        set_bus(sel, addr, 1'b1, 1'b0, 32'h0);
        expect_rd(sel, exp, name);
        set_bus(sel, addr, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Register map vectors, applied with in_port_a = 0x07, edge = 0x01, mask = 0x04
        vecs[0] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h07, 1'b0, "map_wr_data_ignored"};
        vecs[1] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h00, 1'b0, "map_rsvd_reads0"};
        vecs[2] = '{1'b0, 2'd0, 32'h0,         32'h07, 1'b0, "map_data_unchanged"};
        vecs[3] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'hFF, 1'b1, "map_mask_width"};
        vecs[4] = '{1'b0, 2'd3, 32'h0,         32'h01, 1'b1, "map_edge_kept"};
        vecs[5] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h00, 1'b0, "map_edge_clear_all"};
        vecs[6] = '{1'b1, 2'd2, 32'h0,         32'h00, 1'b0, "map_mask_zero"};

        reset = 1'b1;
        set_bus(0, 2'd0, 1'b0, 1'b0, 32'h0);
        set_bus(1, 2'd0, 1'b0, 1'b0, 32'h0);
        in_port_a = 8'h00;
        in_port_b = 8'h00;
        cyc(3);
        check("rst_readdata", readdata_a, 32'h0);
        check_irq(0, 1'b0, "rst_irq");
        reset = 1'b0;
        cyc(2);

        // Build up state, then reset mid-debounce
        wr(0, 2'd2, 32'hFF);
        in_port_a = 8'h01;
        cyc(8);
        check_irq(0, 1'b1, "pre_reset_irq");
        in_port_a = 8'h03;
        cyc(4);
        reset = 1'b1;
        in_port_a = 8'h00;
        #1;
        check_irq(0, 1'b0, "irq_during_reset");
        check("readdata_during_reset", readdata_a, 32'h0);
        cyc(2);
        reset = 1'b0;
        cyc(6);
        rd(0, 2'd0, 32'h0, "post_rst_data");
        rd(0, 2'd1, 32'h0, "post_rst_rsvd");
        rd(0, 2'd2, 32'h0, "post_rst_mask");
        rd(0, 2'd3, 32'h0, "post_rst_edge");
        check_irq(0, 1'b0, "post_rst_irq");

        // Clean edge: stable updates on edge 6, readdata shows it after edge 7
        set_bus(0, 2'd0, 1'b1, 1'b0, 32'h0);
        in_port_a = 8'h05;
        for (int i = 1; i <= 7; i++)
            expect_rd(0, (i >= 7) ? 32'h05 : 32'h00, $sformatf("clean_lat_e%0d", i));
        rd(0, 2'd3, 32'h05, "clean_edgecapture");
        check_irq(0, 1'b0, "clean_irq_masked");

        // Falling bit 0 does not capture in rising mode
        in_port_a = 8'h04;
        cyc(8);
        rd(0, 2'd3, 32'h05, "fall_no_capture");
        wr(0, 2'd3, 32'hFF);
        rd(0, 2'd3, 32'h00, "edge_clear_all");

        // Bounce rejection on bit 0: 1 (3 cycles), 0 (3 cycles), then 1 held
        set_bus(0, 2'd0, 1'b1, 1'b0, 32'h0);
        in_port_a = 8'h05;
        for (int i = 1; i <= 3; i++) expect_rd(0, 32'h04, $sformatf("bounce_hi_%0d", i));
        in_port_a = 8'h04;
        for (int i = 1; i <= 3; i++) expect_rd(0, 32'h04, $sformatf("bounce_lo_%0d", i));
        in_port_a = 8'h05;
        for (int i = 1; i <= 7; i++)
            expect_rd(0, (i >= 7) ? 32'h05 : 32'h04, $sformatf("bounce_hold_e%0d", i));
        rd(0, 2'd3, 32'h01, "bounce_one_capture");

        // IRQ mask
        wr(0, 2'd2, 32'h04);
        rd(0, 2'd2, 32'h04, "mask_readback");
        check_irq(0, 1'b0, "irq_bit0_masked");
        in_port_a = 8'h01;
        cyc(8);
        check_irq(0, 1'b0, "irq_bit2_fall");
        in_port_a = 8'h05;
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            check_irq(0, (i >= 6), $sformatf("irq_bit2_rise_e%0d", i));
        end
        wr(0, 2'd3, 32'h04);
        check_irq(0, 1'b0, "irq_after_clear");
        rd(0, 2'd3, 32'h01, "edge_after_clear");

        // Set/clear collision on bit 1; the read on that edge sees pre-write state
        in_port_a = 8'h07;
        cyc(5);
        set_bus(0, 2'd3, 1'b1, 1'b1, 32'h02);
        expect_rd(0, 32'h01, "collision_edge_read");
        set_bus(0, 2'd3, 1'b0, 1'b0, 32'h0);
        rd(0, 2'd3, 32'h03, "collision_set_wins");
        set_bus(0, 2'd3, 1'b1, 1'b1, 32'h02);
        expect_rd(0, 32'h03, "read_returns_prewrite");
        set_bus(0, 2'd3, 1'b0, 1'b0, 32'h0);
        rd(0, 2'd3, 32'h01, "clear_bit1");

        // Register map table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_wr) wr(0, vecs[i].addr, vecs[i].wdata);
            rd(0, vecs[i].addr, vecs[i].exp_rd, vecs[i].name);
            check_irq(0, vecs[i].exp_irq, {vecs[i].name, "_irq"});
        end

        // Instance B: any-edge, debounce bypassed; stable lags in_port by 2 edges
        wr(1, 2'd2, 32'hFF);
        rd(1, 2'd3, 32'h0, "b_edge_initial");
        set_bus(1, 2'd0, 1'b1, 1'b0, 32'h0);
        in_port_b = 8'hFF;
        for (int i = 1; i <= 5; i++) begin
            expect_rd(1, (i >= 3) ? 32'hFF : 32'h00, $sformatf("b_rise_data_e%0d", i));
            check_irq(1, (i >= 2), $sformatf("b_rise_irq_e%0d", i));
        end
        rd(1, 2'd3, 32'hFF, "b_rise_capture");
        wr(1, 2'd3, 32'hFF);
        check_irq(1, 1'b0, "b_irq_cleared");
        set_bus(1, 2'd0, 1'b1, 1'b0, 32'h0);
        in_port_b = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            expect_rd(1, (i >= 3) ? 32'h00 : 32'hFF, $sformatf("b_fall_data_e%0d", i));
            check_irq(1, (i >= 2), $sformatf("b_fall_irq_e%0d", i));
        end
        rd(1, 2'd3, 32'hFF, "b_fall_capture");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pio_in_debounced.md
Name: pio_in_debounced

Overview:
- Parametrised Avalon-MM slave input port for board switches and push-buttons; next generation of the fixed 3-bit switch PIO.
- Adds an input synchroniser, per-bit debounce and per-bit edge capture with write-1-to-clear.
- Adds an interrupt mask and a level IRQ to the Nios II core.
- Sits between the FPGA pins and the system interconnect; one instance per input group.

Parameters:
- WIDTH, 8: number of input bits (1..32).
- SYNC_STAGES, 2: flip-flop stages in the synchroniser (2..4).
- DEBOUNCE_CYCLES, 50000: cycles an input must differ from the stable value before the stable value updates. 0 bypasses debounce.
- EDGE_MODE, 0: edge that sets capture bits. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- address  in  2  Avalon register select
- chipselect  in  1  slave select
- write  in  1  write strobe, qualified by chipselect
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous pin inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt request

Behaviour:
- Reset (async assert, sync deassert by system) clears: sync chain, debounce counters, stable value, mask, edgecapture, readdata. irq is 0 during reset.
- Reset mid-debounce discards any count in progress.
- Synchroniser: sync = in_port delayed SYNC_STAGES edges.
- Debounce, per bit with an independent counter (width clog2(DEBOUNCE_CYCLES)):
  - If sync == stable, counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1, then stable <= sync and counter <= 0.
  - Else counter++.
  - The stable bit therefore changes DEBOUNCE_CYCLES edges after sync first differs; any bounce back restarts the count.
  - Total pin-to-stable latency = SYNC_STAGES + DEBOUNCE_CYCLES edges.
  - DEBOUNCE_CYCLES = 0: stable <= sync every edge.
- Edge capture:
  - An edgecapture bit sets on the same edge its stable bit updates, if the transition matches EDGE_MODE.
  - Bits are sticky until cleared.
  - A power-up input at 1 produces a rising edge after the debounce latency, because stable resets to 0.
- Register map (address):
  - 0 data: stable value, zero-extended. Read-only; writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 irqmask: RW, WIDTH bits.
  - 3 edgecapture: read returns capture bits. A write with chipselect && write clears each bit where writedata bit = 1.
- Write priority: if a set event and a clear occur on the same edge for the same bit, the set wins and the bit stays 1.
- Read:
  - readdata <= mux(address) on every clock edge; valid 1 cycle after the address is presented. Read latency is 1; no wait states.
  - Bits above WIDTH are 0.
  - A read and write on the same edge return the pre-write value.
- irq = |(edgecapture & irqmask).
  - Combinational from registers, so it asserts in the cycle after the capturing edge.
  - Deasserts the cycle after the clearing write, or after the mask write that zeroes the relevant bits.
- No X propagation: unused writedata bits are ignored.

Decomposition:
- Shared package pio_pkg holds:
  - address constants: PIO_ADDR_DATA = 0, PIO_ADDR_RSVD = 1, PIO_ADDR_MASK = 2, PIO_ADDR_EDGE = 3
  - EDGE_MODE encodings: EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2
- One sub-module, pio_debounce_bit, instantiated in a generate loop over WIDTH:
  - contains the synchroniser chain, counter and stable flop for one bit
  - outputs stable and a one-cycle rise/fall pulse pair
- Top level holds the mask, edgecapture, read mux and irq.

Test Plan (bench uses WIDTH = 8, SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, EDGE_MODE = 0 unless stated):
- Reset and clean edge: assert reset with in_port = 0x00; mid-run raise reset, then release -> all registers read 0 and irq = 0. Then in_port = 0x05 -> data reads 0x05 exactly 6 edges later and edgecapture reads 0x05.
- Bounce rejection: toggle in_port[0] 1,0,1 with each level held 3 cycles, then hold 1 -> stable updates only 4 cycles after the final hold reaches sync. Exactly one capture occurs.
- IRQ mask: write mask = 0x04; bit 0 edge -> irq stays 0. Bit 2 edge -> irq = 1. Write 0x04 to address 3 -> irq = 0 next cycle and edgecapture = 0x01.
- Set/clear collision: a write-1-to-clear of bit 1 on the same edge that bit 1 captures -> edgecapture bit 1 reads 1.
- EDGE_MODE = 2 and DEBOUNCE_CYCLES = 0: in_port 0x00 -> 0xFF -> 0x00, each level held 5 cycles -> captures on both transitions. Data follows in_port with 2-cycle latency.
- Register map: write 0xFFFFFFFF to addresses 0 and 1 -> both unaffected; address 1 reads 0. Write 0xFFFFFFFF to address 2 -> mask reads 0x000000FF.
